signed_seq_divider: RTL and testbench
=====================================

// Module: signed_seq_divider
// PURPOSE
//   Sequential signed divider: 2W-bit dividend / W-bit divisor -> W-bit quotient + W-bit remainder,
//   one quotient bit per clock (restoring, on magnitudes). Inverse datapath of the Radix-4 multiplier:
//   a 64-bit product and one 32-bit operand recover the other operand. Start/done handshake to host FSM.
// PARAMETERS
//   WIDTH  32  operand width W; dividend is 2W bits; W >= 4
// PORTS
//   clk        in   1     rising-edge clock
//   reset      in   1     asynchronous, active-low reset (0 = reset)
//   start      in   1     request; sampled only in IDLE
//   dividend   in   2W    signed, two's complement; captured on accepted start
//   divisor    in   W     signed, two's complement; captured on accepted start
//   busy       out  1     high from cycle after accepted start until done
//   done       out  1     one-cycle pulse; results valid from this cycle
//   quotient   out  W     signed quotient, truncated toward zero
//   remainder  out  W     signed remainder, sign of dividend (or 0)
//   div_zero   out  1     divisor was 0
//   overflow   out  1     quotient not representable in W signed bits
// BEHAVIOUR
//   Reset: state IDLE; busy, done, div_zero, overflow = 0; quotient, remainder = 0. Reset mid-op aborts, no done.
//   FSM IDLE -> ABS -> ITER (W cycles) -> FIX -> IDLE; done pulses on FIX->IDLE.
//   IDLE: start=1 captures operands, signs sq=dvd[2W-1]^dvs[W-1], sr=dvd[2W-1]; -> ABS.
//   ABS (1 cyc): |dvd|, |dvs| (negate via two's complement, 2W / W bits, unsigned result).
//     divisor==0  -> quotient all-ones, remainder=dividend[W-1:0], div_zero=1, done; -> IDLE.
//     |dvd|[2W-1:W] >= |dvs| -> overflow=1, quotient=remainder=0, done; -> IDLE.
//   ITER: W+1-bit partial rem P, shift in next dividend bit; if P>=|dvs| subtract, q bit=1; W cycles, counter 0..W-1.
//   FIX (1 cyc): apply signs; if sq and |q|>2^(W-1), or !sq and |q|>2^(W-1)-1 -> overflow=1, q=r=0.
//     q = -(2^(W-1)) with sq=1 is legal (no overflow).
//   Latency start->done: W+2 cycles normal; 2 cycles for div_zero/overflow-at-ABS.
//   start while busy: ignored (no queueing). start in same cycle as done: ignored; accepted next cycle.
//   Outputs & flags hold until next accepted start; flags cleared on accepted start.
// STRUCTURE
//   Shared include divider_defs.vh: state localparams (IDLE, ABS, ITER, FIX), WIDTH default,
//   counter width = clog2(WIDTH). Sub-module twos_negate #(N) (conditional negate), instanced for
//   |dividend|, |divisor|, sign-fix of quotient and remainder. All other logic in this module.
// TESTING (W=32; check done at cycle 34 after start unless noted)
//   0x000000001BB6BAA0 / 0x00000348 -> q=0x00087234, r=0; also 0x1BB6BAA5 -> r=0x5.
//   0x193DE4CED7437964 / 0x50612336 -> q=0x50647236, r=0; 0xFFFFFFFFF7747564 / 0x00087234 -> q=0xFFFFFEFD, r=0.
//   -0x1BB6BAA5 (0xFFFFFFFFE449455B) / 0x348 -> q=0xFFF78DCC, r=0xFFFFFFFB.
//   divisor 0, dividend 0x1234 -> done at cycle 2, div_zero=1, q=0xFFFFFFFF, r=0x00001234.
//   0x0000000100000000 / 1 -> overflow=1 (cycle 2); 0xFFFFFFFF80000000 / 1 -> q=0x80000000, overflow=0.
//   reset low at ITER cycle 10 -> busy=0, no done; start again -> correct result; start pulsed while busy ignored.

Source files
------------

// File: rtl/signed_seq_divider_pkg.sv
// Shared state encoding and default sizing for the signed sequential divider.
package signed_seq_divider_pkg;

    localparam int DIV_WIDTH_DEF = 32;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_ABS  = 2'd1,
        S_ITER = 2'd2,
        S_FIX  = 2'd3
    } div_state_e;

    function automatic int cnt_width(input int w);
        return (w > 1) ? $clog2(w) : 1;
    endfunction

endpackage

// File: rtl/signed_seq_divider_twos_negate.sv
// Conditional two's-complement negate; used for operand magnitudes and result sign fix-up.
module twos_negate #(
    parameter int N = 32
) (
    input  logic [N-1:0] a,
    input  logic         neg,
    output logic [N-1:0] y
);

    assign y = neg ? (~a + N'(1)) : a;

endmodule

// File: rtl/signed_seq_divider.sv
// Signed 2W/W restoring divider, one quotient bit per clock, start/done handshake.
//
//   state  | meaning
//   IDLE   | waiting for start; results and flags held
//   ABS    | operand magnitudes formed; divide-by-zero and early overflow resolved
//   ITER   | one restoring step per cycle, W cycles
//   FIX    | signed results posted, done high for this one cycle
module signed_seq_divider
    import signed_seq_divider_pkg::*;
#(
    parameter int WIDTH = DIV_WIDTH_DEF
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 start,
    input  logic [2*WIDTH-1:0]   dividend,
    input  logic [WIDTH-1:0]     divisor,
    output logic                 busy,
    output logic                 done,
    output logic [WIDTH-1:0]     quotient,
    output logic [WIDTH-1:0]     remainder,
    output logic                 div_zero,
    output logic                 overflow
);

    localparam int               CW       = cnt_width(WIDTH);
    localparam logic [CW-1:0]    CNT_LAST = CW'(WIDTH - 1);
    localparam logic [WIDTH-1:0] MIN_MAG  = {1'b1, {(WIDTH-1){1'b0}}};

    div_state_e         state_q, state_d;
    logic [2*WIDTH-1:0] dvd_q, dvd_d;
    logic [WIDTH-1:0]   dvs_q, dvs_d;
    logic               sq_q, sq_d, sr_q, sr_d;
    logic [WIDTH-1:0]   lo_q, lo_d;
    logic [WIDTH:0]     p_q, p_d;
    logic [WIDTH-1:0]   q_q, q_d;
    logic [CW-1:0]      cnt_q, cnt_d;
    logic               busy_q, busy_d, done_q, done_d;
    logic [WIDTH-1:0]   quo_q, quo_d, rem_q, rem_d;
    logic               dz_q, dz_d, ovf_q, ovf_d;

    logic [2*WIDTH-1:0] dvd_abs;
    logic [WIDTH-1:0]   dvs_abs;
    logic [WIDTH:0]     p_sh, p_nx;
    logic               ge;
    logic [WIDTH-1:0]   q_nx, q_signed, r_signed, q_lim;
    logic               fix_ovf;

    twos_negate #(.N(2*WIDTH)) u_neg_dvd (.a(dvd_q), .neg(dvd_q[2*WIDTH-1]), .y(dvd_abs));
    twos_negate #(.N(WIDTH))   u_neg_dvs (.a(dvs_q), .neg(dvs_q[WIDTH-1]),   .y(dvs_abs));

    // dvs_q holds the divisor magnitude once ITER is entered.
    assign p_sh = {p_q[WIDTH-1:0], lo_q[WIDTH-1]};
    assign ge   = (p_sh >= {1'b0, dvs_q});
    assign p_nx = ge ? (p_sh - {1'b0, dvs_q}) : p_sh;
    assign q_nx = {q_q[WIDTH-2:0], ge};

    twos_negate #(.N(WIDTH)) u_neg_quo (.a(q_nx),              .neg(sq_q), .y(q_signed));
    twos_negate #(.N(WIDTH)) u_neg_rem (.a(p_nx[WIDTH-1:0]),   .neg(sr_q), .y(r_signed));

    // A negative quotient may reach -2^(W-1); a positive one stops one short.
    assign q_lim   = sq_q ? MIN_MAG : (MIN_MAG - WIDTH'(1));
    assign fix_ovf = (q_nx > q_lim);

    always_comb begin
        state_d = state_q;
        dvd_d   = dvd_q;
        dvs_d   = dvs_q;
        sq_d    = sq_q;
        sr_d    = sr_q;
        lo_d    = lo_q;
        p_d     = p_q;
        q_d     = q_q;
        cnt_d   = cnt_q;
        busy_d  = busy_q;
        done_d  = 1'b0;
        quo_d   = quo_q;
        rem_d   = rem_q;
        dz_d    = dz_q;
        ovf_d   = ovf_q;

        unique case (state_q)
            S_IDLE: begin
                if (start) begin
                    dvd_d   = dividend;
                    dvs_d   = divisor;
                    sq_d    = dividend[2*WIDTH-1] ^ divisor[WIDTH-1];
                    sr_d    = dividend[2*WIDTH-1];
                    busy_d  = 1'b1;
                    dz_d    = 1'b0;
                    ovf_d   = 1'b0;
                    state_d = S_ABS;
                end
            end
            S_ABS: begin
                if (dvs_q == '0) begin
                    quo_d   = '1;
                    rem_d   = dvd_q[WIDTH-1:0];
                    dz_d    = 1'b1;
                    busy_d  = 1'b0;
                    done_d  = 1'b1;
                    state_d = S_FIX;
                end else if (dvd_abs[2*WIDTH-1:WIDTH] >= dvs_abs) begin
                    quo_d   = '0;
                    rem_d   = '0;
                    ovf_d   = 1'b1;
                    busy_d  = 1'b0;
                    done_d  = 1'b1;
                    state_d = S_FIX;
                end else begin
                    lo_d    = dvd_abs[WIDTH-1:0];
                    p_d     = {1'b0, dvd_abs[2*WIDTH-1:WIDTH]};
                    dvs_d   = dvs_abs;
                    q_d     = '0;
                    cnt_d   = '0;
                    state_d = S_ITER;
                end
            end
            S_ITER: begin
                lo_d  = {lo_q[WIDTH-2:0], 1'b0};
                p_d   = p_nx;
                q_d   = q_nx;
                cnt_d = cnt_q + CW'(1);
                // Last step feeds the sign fix-up directly so results land with done.
                if (cnt_q == CNT_LAST) begin
                    if (fix_ovf) begin
                        quo_d = '0;
                        rem_d = '0;
                        ovf_d = 1'b1;
                    end else begin
                        quo_d = q_signed;
                        rem_d = r_signed;
                    end
                    busy_d  = 1'b0;
                    done_d  = 1'b1;
                    state_d = S_FIX;
                end
            end
            S_FIX: begin
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q <= S_IDLE;
            dvd_q   <= '0;
            dvs_q   <= '0;
            sq_q    <= 1'b0;
            sr_q    <= 1'b0;
            lo_q    <= '0;
            p_q     <= '0;
            q_q     <= '0;
            cnt_q   <= '0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
            quo_q   <= '0;
            rem_q   <= '0;
            dz_q    <= 1'b0;
            ovf_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            dvd_q   <= dvd_d;
            dvs_q   <= dvs_d;
            sq_q    <= sq_d;
            sr_q    <= sr_d;
            lo_q    <= lo_d;
            p_q     <= p_d;
            q_q     <= q_d;
            cnt_q   <= cnt_d;
            busy_q  <= busy_d;
            done_q  <= done_d;
            quo_q   <= quo_d;
            rem_q   <= rem_d;
            dz_q    <= dz_d;
            ovf_q   <= ovf_d;
        end
    end

    assign busy      = busy_q;
    assign done      = done_q;
    assign quotient  = quo_q;
    assign remainder = rem_q;
    assign div_zero  = dz_q;
    assign overflow  = ovf_q;

endmodule

// File: tb/tb_signed_seq_divider.sv
// Self-checking bench for signed_seq_divider: directed corner cases plus randomized operands
// compared against a magnitude/plain-division reference model.
module tb_signed_seq_divider;

    localparam int W = 32;

    logic          clk = 1'b0;
    logic          reset = 1'b0;
    logic          start = 1'b0;
    logic [63:0]   dividend = '0;
    logic [31:0]   divisor = '0;
    logic          busy, done, div_zero, overflow;
    logic [31:0]   quotient, remainder;

    int total = 0;
    int bad = 0;

    signed_seq_divider #(.WIDTH(W)) dut (
        .clk(clk), .reset(reset), .start(start),
        .dividend(dividend), .divisor(divisor),
        .busy(busy), .done(done),
        .quotient(quotient), .remainder(remainder),
        .div_zero(div_zero), .overflow(overflow)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s: observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    // Reference: magnitudes, plain 64-bit division, then signs and range rules.
    task automatic model(input logic [63:0] dvd, input logic [31:0] dvs,
                         output logic [31:0] eq, output logic [31:0] er,
                         output logic edz, output logic eov, output int elat);
        logic [63:0] md, mq, mr, lim, nq, nr;
        logic [31:0] ms;
        logic        sq, sr;
        sr   = dvd[63];
        sq   = dvd[63] ^ dvs[31];
        md   = sr ? -dvd : dvd;
        ms   = dvs[31] ? -dvs : dvs;
        edz  = 1'b0;
        eov  = 1'b0;
        elat = 34;
        eq   = '0;
        er   = '0;
        if (dvs == 32'd0) begin
            eq   = '1;
            er   = dvd[31:0];
            edz  = 1'b1;
            elat = 2;
        end else begin
            mq  = md / {32'd0, ms};
            mr  = md % {32'd0, ms};
            lim = sq ? 64'h0000_0000_8000_0000 : 64'h0000_0000_7FFF_FFFF;
            if (mq >= 64'h0000_0001_0000_0000) elat = 2;
            if (mq > lim) begin
                eov = 1'b1;
            end else begin
                nq = -mq;
                nr = -mr;
                eq = sq ? nq[31:0] : mq[31:0];
                er = sr ? nr[31:0] : mr[31:0];
            end
        end
    endtask

    task automatic launch(input logic [63:0] dvd, input logic [31:0] dvs);
        @(negedge clk);
        dividend = dvd;
        divisor  = dvs;
        start    = 1'b1;
        @(negedge clk);
        start    = 1'b0;
    endtask

    // Entered in cycle 1 after the accepting edge; returns in the done cycle.
    task automatic collect(input string tag, input logic [63:0] dvd, input logic [31:0] dvs,
                           input int pulse_cyc);
        logic [31:0] eq, er;
        logic        edz, eov;
        int          elat, cyc;
        model(dvd, dvs, eq, er, edz, eov, elat);
        cyc = 1;
        check({tag, ".busy1"}, 64'(busy), 64'd1);
        while (done !== 1'b1 && cyc < 60) begin
            if (cyc == pulse_cyc) begin
                start    = 1'b1;
                dividend = ~dvd;
                divisor  = dvs + 32'd1;
            end else begin
                start = 1'b0;
            end
            @(negedge clk);
            cyc++;
        end
        start = 1'b0;
        check({tag, ".latency"}, 64'(cyc), 64'(elat));
        check({tag, ".busy_end"}, 64'(busy), 64'd0);
        check({tag, ".q"}, 64'(quotient), 64'(eq));
        check({tag, ".r"}, 64'(remainder), 64'(er));
        check({tag, ".dz"}, 64'(div_zero), 64'(edz));
        check({tag, ".ovf"}, 64'(overflow), 64'(eov));
    endtask

    task automatic run_op(input string tag, input logic [63:0] dvd, input logic [31:0] dvs);
        launch(dvd, dvs);
        collect(tag, dvd, dvs, 0);
        @(negedge clk);
        check({tag, ".pulse"}, 64'(done), 64'd0);
    endtask

    initial begin
        logic [31:0] dv, qv;
        logic [63:0] dd, prod;
        int          seen;

        repeat (3) @(negedge clk);
        check("rst.busy", 64'(busy), 64'd0);
        check("rst.done", 64'(done), 64'd0);
        check("rst.q", 64'(quotient), 64'd0);
        check("rst.r", 64'(remainder), 64'd0);
        check("rst.dz", 64'(div_zero), 64'd0);
        check("rst.ovf", 64'(overflow), 64'd0);
        reset = 1'b1;
        @(negedge clk);

        run_op("exact", 64'h0000_0000_1BB6_BAA0, 32'h0000_0348);
        check("exact.q_const", 64'(quotient), 64'h0008_7234);
        run_op("rem5", 64'h0000_0000_1BB6_BAA5, 32'h0000_0348);
        check("rem5.r_const", 64'(remainder), 64'h5);
        run_op("big", 64'h193D_E4CE_D743_7964, 32'h5061_2336);
        run_op("negdvd", 64'hFFFF_FFFF_F774_7564, 32'h0008_7234);
        check("negdvd.q_const", 64'(quotient), 64'hFFFF_FEFD);
        run_op("negrem", 64'hFFFF_FFFF_E449_455B, 32'h0000_0348);
        check("negrem.q_const", 64'(quotient), 64'hFFF7_8DCC);
        check("negrem.r_const", 64'(remainder), 64'hFFFF_FFFB);
        run_op("divzero", 64'h0000_0000_0000_1234, 32'h0);
        check("divzero.r_const", 64'(remainder), 64'h1234);
        run_op("divzero_neg", 64'hFFFF_FFF0_8765_4321, 32'h0);
        run_op("ovf_abs", 64'h0000_0001_0000_0000, 32'h1);
        run_op("minq", 64'hFFFF_FFFF_8000_0000, 32'h1);
        check("minq.q_const", 64'(quotient), 64'h8000_0000);
        run_op("ovf_fix", 64'h0000_0000_8000_0000, 32'h1);
        run_op("ovf_min", 64'h8000_0000_0000_0000, 32'hFFFF_FFFF);
        run_op("neg_neg", 64'hFFFF_FFFF_FFFF_FFFF, 32'hFFFF_FFFF);
        run_op("min_dvs", 64'h3FFF_FFFF_FFFF_FFFF, 32'h8000_0000);
        run_op("zero_dvd", 64'h0, 32'hFFFF_FFF9);

        // Reset in the middle of the iteration phase.
        launch(64'h0000_0000_1BB6_BAA5, 32'h0000_0348);
        repeat (11) @(negedge clk);
        reset = 1'b0;
        #1;
        check("midrst.busy", 64'(busy), 64'd0);
        check("midrst.done", 64'(done), 64'd0);
        check("midrst.q", 64'(quotient), 64'd0);
        @(negedge clk);
        reset = 1'b1;
        seen = 0;
        repeat (40) begin
            @(negedge clk);
            if (done === 1'b1) seen = 1;
        end
        check("midrst.no_done", 64'(seen), 64'd0);
        run_op("after_rst", 64'h0000_0000_1BB6_BAA5, 32'h0000_0348);
        check("after_rst.q_const", 64'(quotient), 64'h0008_7234);

        // Start pulsed while busy must not disturb the running operation.
        launch(64'hFFFF_FFFF_E449_455B, 32'h0000_0348);
        collect("busy_pulse", 64'hFFFF_FFFF_E449_455B, 32'h0000_0348, 5);
        @(negedge clk);
        check("busy_pulse.pulse", 64'(done), 64'd0);

        // Start raised in the done cycle is ignored there and taken the cycle after.
        launch(64'h0000_0000_1BB6_BAA0, 32'h0000_0348);
        collect("b2b_a", 64'h0000_0000_1BB6_BAA0, 32'h0000_0348, 0);
        dividend = 64'hFFFF_FFFF_F774_7564;
        divisor  = 32'h0008_7234;
        start    = 1'b1;
        @(negedge clk);
        check("b2b.ignored", 64'(busy), 64'd0);
        check("b2b.hold_q", 64'(quotient), 64'h0008_7234);
        @(negedge clk);
        start = 1'b0;
        collect("b2b_b", 64'hFFFF_FFFF_F774_7564, 32'h0008_7234, 0);
        @(negedge clk);

        for (int i = 0; i < 24; i++) begin
            dv = $urandom;
            qv = $urandom >> $urandom_range(1, 31);
            if ($urandom_range(0, 1) == 1) qv = -qv;
            case (i % 4)
                0: begin
                    prod = 64'(longint'($signed(qv)) * longint'($signed(dv)));
                    dd   = prod + 64'($urandom_range(0, 200));
                end
                1: begin
                    dv   = 32'($urandom_range(1, 255));
                    if ($urandom_range(0, 1) == 1) dv = -dv;
                    prod = 64'(longint'($signed(qv)) * longint'($signed(dv)));
                    dd   = prod - 64'($urandom_range(0, 200));
                end
                2: begin
                    dd = {32'($urandom), 32'($urandom)};
                    if (i % 8 == 2) dv = 32'd0;
                end
                default: begin
                    dd = {{32{qv[31]}}, qv};
                    dv = dv >> $urandom_range(0, 31);
                end
            endcase
            run_op($sformatf("rand%0d", i), dd, dv);
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
